// File: rtl/readout_pkg.sv
// Shared definitions for the readout trigger controller.
// Holds the frame FSM state encoding and the default width of the timing and
// frame-count fields.
package readout_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  localparam int unsigned RTC_STATE_W = 3;

  localparam logic [RTC_STATE_W-1:0] RTC_IDLE      = 3'd0;
  localparam logic [RTC_STATE_W-1:0] RTC_EXPOSE    = 3'd1;
  localparam logic [RTC_STATE_W-1:0] RTC_TRIG      = 3'd2;
  localparam logic [RTC_STATE_W-1:0] RTC_WAIT_ACK  = 3'd3;
  localparam logic [RTC_STATE_W-1:0] RTC_WAIT_DONE = 3'd4;
  localparam logic [RTC_STATE_W-1:0] RTC_GAP       = 3'd5;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the exposure, gap and timeout phases.
// A load of N makes `expired` true N cycles later. The counter then holds
// at zero until the next load.
// Ports:
//   CLK      in  clock
//   rst      in  synchronous active-high reset
//   load     in  load load_val this cycle
//   load_val in  W-bit value to load
//   value    out current count
//   expired  out count has reached zero
module cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value   = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/readout_trigger_ctrl.sv
// Frame-level initiator for the row readout sequencer.
// Runs exposure, issues a one-cycle readout trigger, follows the sequencer's
// re_busy through acknowledge and completion, and repeats for NUM_FRAME frames
// (0 = until stop), with T_gap idle cycles between frames.
// Ports:
//   CLK, rst                      clock, synchronous active-high reset
//   start, stop                   run control levels
//   T_exp, T_gap, T_timeout       timing fields, latched on an accepted start
//   NUM_FRAME                     frames per run, latched on an accepted start
//   re_busy                       sequencer busy flag
//   trigger, EXP, run_busy, done  registered status / strobes
//   err_timeout                   sticky acknowledge-timeout flag
//   frame_cnt                     frames completed in the current run
module readout_trigger_ctrl
  import readout_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] T_exp,
  input  logic [CNT_W-1:0] T_gap,
  input  logic [CNT_W-1:0] T_timeout,
  input  logic [CNT_W-1:0] NUM_FRAME,
  input  logic             re_busy,
  output logic             trigger,
  output logic             EXP,
  output logic             run_busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  // Timer reload value for a phase of `len` cycles; 0 behaves as 1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  logic [RTC_STATE_W-1:0] state_q, state_d;

  logic [CNT_W-1:0] t_exp_q, t_gap_q, t_timeout_q, n_frame_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             err_q, err_d;
  logic             trig_q, trig_d;
  logic             exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Decisions from the next-state logic consumed by the output logic.
  logic             accept;
  logic             frame_inc;
  logic             run_end;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expired;

  cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  // Only the expiry flag drives decisions; the raw count is informational.
  logic unused_tmr_value;
  assign unused_tmr_value = ^tmr_value;

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= RTC_IDLE;
      t_exp_q     <= '0;
      t_gap_q     <= '0;
      t_timeout_q <= '0;
      n_frame_q   <= '0;
      frame_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      trig_q      <= 1'b0;
      exp_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        t_exp_q     <= T_exp;
        t_gap_q     <= T_gap;
        t_timeout_q <= T_timeout;
        n_frame_q   <= NUM_FRAME;
      end
      frame_cnt_q <= frame_cnt_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
      trig_q      <= trig_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, timer reloads and run bookkeeping.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    accept      = 1'b0;
    frame_inc   = 1'b0;
    run_end     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      RTC_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          accept   = 1'b1;
          err_d    = 1'b0;
          state_d  = RTC_EXPOSE;
          tmr_load = 1'b1;
          tmr_val  = len_m1(T_exp);
        end
      end

      RTC_EXPOSE: begin
        if (stop) begin
          state_d = RTC_IDLE;
          run_end = 1'b1;
        end else if (tmr_expired) begin
          state_d = RTC_TRIG;
        end
      end

      RTC_TRIG: begin
        stop_pend_d = stop_pend_q | stop;
        state_d     = RTC_WAIT_ACK;
        tmr_load    = 1'b1;
        tmr_val     = len_m1(t_timeout_q);
      end

      RTC_WAIT_ACK: begin
        stop_pend_d = stop_pend_q | stop;
        // An acknowledge in the final allowed cycle still counts.
        if (re_busy) begin
          state_d = RTC_WAIT_DONE;
        end else if ((t_timeout_q != '0) && tmr_expired) begin
          err_d   = 1'b1;
          state_d = RTC_IDLE;
        end
      end

      RTC_WAIT_DONE: begin
        stop_pend_d = stop_pend_q | stop;
        if (!re_busy) begin
          frame_inc = 1'b1;
          if (((frame_cnt_q + 1'b1 == n_frame_q) && (n_frame_q != '0)) ||
              stop_pend_q || stop) begin
            state_d = RTC_IDLE;
            run_end = 1'b1;
          end else if (t_gap_q == '0) begin
            state_d  = RTC_EXPOSE;
            tmr_load = 1'b1;
            tmr_val  = len_m1(t_exp_q);
          end else begin
            state_d  = RTC_GAP;
            tmr_load = 1'b1;
            tmr_val  = t_gap_q - 1'b1;
          end
        end
      end

      RTC_GAP: begin
        if (stop) begin
          state_d = RTC_IDLE;
          run_end = 1'b1;
        end else if (tmr_expired) begin
          state_d  = RTC_EXPOSE;
          tmr_load = 1'b1;
          tmr_val  = len_m1(t_exp_q);
        end
      end

      default: begin
        state_d = RTC_IDLE;
      end
    endcase
  end

  // Output values follow the state being entered, so they are valid on the
  // same edge as the transition.
  always_comb begin
    trig_d = (state_d == RTC_TRIG);
    exp_d  = (state_d == RTC_EXPOSE);
    busy_d = (state_d != RTC_IDLE);
    done_d = run_end;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      frame_cnt_d = '0;
    end else if (frame_inc) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  assign trigger     = trig_q;
  assign EXP         = exp_q;
  assign run_busy    = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_readout_trigger_ctrl.sv
// Directed bench for readout_trigger_ctrl with a behavioural sequencer model.
module tb_readout_trigger_ctrl;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] T_exp = '0;
  logic [31:0] T_gap = '0;
  logic [31:0] T_timeout = '0;
  logic [31:0] NUM_FRAME = '0;
  logic        re_busy = 1'b0;
  logic        trigger;
  logic        EXP;
  logic        run_busy;
  logic        done;
  logic        err_timeout;
  logic [31:0] frame_cnt;

  readout_trigger_ctrl #(
    .CNT_W (32)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .T_exp       (T_exp),
    .T_gap       (T_gap),
    .T_timeout   (T_timeout),
    .NUM_FRAME   (NUM_FRAME),
    .re_busy     (re_busy),
    .trigger     (trigger),
    .EXP         (EXP),
    .run_busy    (run_busy),
    .done        (done),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Sequencer: re_busy rises 2 cycles after trigger rises, stays rd_len cycles.
  int   rd_len = 20;
  bit   model_en = 1'b1;
  logic trig_d1 = 1'b0;
  int   rd_cnt = 0;

  always @(posedge CLK) begin
    trig_d1 <= trigger;
    if (model_en && trig_d1) begin
      re_busy <= 1'b1;
      rd_cnt  <= rd_len;
    end else if (re_busy) begin
      if (rd_cnt <= 1) re_busy <= 1'b0;
      else rd_cnt <= rd_cnt - 1;
    end
  end

  // Event counters sampled on the falling edge.
  int          exp_cyc = 0, trig_cyc = 0, done_cyc = 0, exp_rise = 0;
  int          trig_after_exp = 0, trig_double = 0, gaps_seen = 0, gap_run = 0;
  logic        exp_prev = 1'b0, trig_prev = 1'b0, gap_active = 1'b0;
  logic [31:0] fc_prev = '0;
  int          gap_log [16];

  always @(negedge CLK) begin
    exp_cyc  <= exp_cyc + (EXP ? 1 : 0);
    trig_cyc <= trig_cyc + (trigger ? 1 : 0);
    done_cyc <= done_cyc + (done ? 1 : 0);
    if (EXP && !exp_prev) exp_rise <= exp_rise + 1;
    if (trigger && exp_prev) trig_after_exp <= trig_after_exp + 1;
    if (trigger && trig_prev) trig_double <= trig_double + 1;
    // Idle cycles from a frame completion to the next EXP rise.
    if (!run_busy) begin
      gap_active <= 1'b0;
    end else if (frame_cnt == fc_prev + 32'd1) begin
      gap_active <= 1'b1;
      gap_run    <= EXP ? 0 : 1;
    end else if (gap_active) begin
      if (EXP) begin
        gap_log[gaps_seen % 16] <= gap_run;
        gaps_seen  <= gaps_seen + 1;
        gap_active <= 1'b0;
      end else begin
        gap_run <= gap_run + 1;
      end
    end
    exp_prev  <= EXP;
    trig_prev <= trigger;
    fc_prev   <= frame_cnt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return run_busy;
      1:       return re_busy;
      2:       return trigger;
      3:       return err_timeout;
      5:       return (frame_cnt != 32'd0);
      default: return EXP;
    endcase
  endfunction

  // Waits on falling edges until the selected signal equals val, bounded.
  task automatic wait_for(input string tag, input int sel, input logic val, input int budget,
                          output int cyc);
    cyc = 0;
    while (sig(sel) !== val && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    check(tag, {31'd0, sig(sel)}, {31'd0, val});
  endtask

  task automatic cfg(input int te, input int tg, input int tt, input int nf, input int rl);
    T_exp = te; T_gap = tg; T_timeout = tt; NUM_FRAME = nf; rd_len = rl;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int cyc;
    int e0, t0, d0, r0, g0;

    repeat (2) @(negedge CLK);
    check("rst_trigger", {31'd0, trigger}, 0);
    check("rst_exp", {31'd0, EXP}, 0);
    check("rst_busy", {31'd0, run_busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err_timeout}, 0);
    check("rst_fcnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge CLK);

    // Single frame.
    cfg(5, 0, 0, 1, 20);
    e0 = exp_cyc; t0 = trig_cyc; d0 = done_cyc; r0 = exp_rise;
    pulse_start();
    check("t1_start_exp", {31'd0, EXP}, 1);
    check("t1_start_busy", {31'd0, run_busy}, 1);
    wait_for("t1_idle", 0, 1'b0, 200, cyc);
    settle();
    check("t1_exp_cycles", exp_cyc - e0, 5);
    check("t1_triggers", trig_cyc - t0, 1);
    check("t1_dones", done_cyc - d0, 1);
    check("t1_exp_rises", exp_rise - r0, 1);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_busy_after", {31'd0, run_busy}, 0);

    // Multi-frame with gap; a start mid-run must be ignored.
    cfg(3, 4, 0, 3, 6);
    e0 = exp_cyc; t0 = trig_cyc; d0 = done_cyc; g0 = gaps_seen;
    pulse_start();
    wait_for("t2_frame1", 5, 1'b1, 100, cyc);
    pulse_start();
    wait_for("t2_idle", 0, 1'b0, 300, cyc);
    settle();
    check("t2_triggers", trig_cyc - t0, 3);
    check("t2_exp_cycles", exp_cyc - e0, 9);
    check("t2_dones", done_cyc - d0, 1);
    check("t2_fcnt", frame_cnt, 3);
    check("t2_gaps", gaps_seen - g0, 2);
    check("t2_gap0", gap_log[g0 % 16], 4);
    check("t2_gap1", gap_log[(g0 + 1) % 16], 4);

    // Acknowledge timeout with the sequencer silent.
    model_en = 1'b0;
    cfg(2, 0, 10, 1, 20);
    d0 = done_cyc;
    pulse_start();
    wait_for("t3_trig", 2, 1'b1, 50, cyc);
    wait_for("t3_err", 3, 1'b1, 50, cyc);
    check("t3_timeout_lat", cyc, 11);
    check("t3_idle", {31'd0, run_busy}, 0);
    repeat (5) @(negedge CLK);
    check("t3_err_sticky", {31'd0, err_timeout}, 1);
    settle();
    check("t3_no_done", done_cyc - d0, 0);
    check("t3_fcnt", frame_cnt, 0);
    model_en = 1'b1;
    cfg(2, 0, 0, 1, 5);
    pulse_start();
    check("t3_err_clear", {31'd0, err_timeout}, 0);
    wait_for("t3_idle2", 0, 1'b0, 100, cyc);
    settle();

    // T_timeout=1 cannot see the acknowledge in time.
    cfg(2, 0, 1, 1, 5);
    d0 = done_cyc;
    pulse_start();
    wait_for("t3b_idle", 0, 1'b0, 100, cyc);
    settle();
    check("t3b_err", {31'd0, err_timeout}, 1);
    check("t3b_no_done", done_cyc - d0, 0);
    repeat (10) @(negedge CLK);

    // Stop mid-exposure.
    cfg(100, 0, 0, 0, 20);
    e0 = exp_cyc; t0 = trig_cyc; d0 = done_cyc;
    pulse_start();
    repeat (29) @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("t4_exp_drop", {31'd0, EXP}, 0);
    check("t4_done", {31'd0, done}, 1);
    check("t4_busy", {31'd0, run_busy}, 0);
    settle();
    check("t4_exp_cycles", exp_cyc - e0, 30);
    check("t4_no_trigger", trig_cyc - t0, 0);
    check("t4_dones", done_cyc - d0, 1);
    check("t4_fcnt", frame_cnt, 0);

    // Stop during readout in continuous mode; T_timeout=2 is just enough.
    cfg(3, 2, 2, 0, 10);
    t0 = trig_cyc; d0 = done_cyc; r0 = exp_rise;
    pulse_start();
    wait_for("t5_rb", 1, 1'b1, 50, cyc);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    wait_for("t5_idle", 0, 1'b0, 100, cyc);
    repeat (20) @(negedge CLK);
    check("t5_fcnt", frame_cnt, 1);
    check("t5_dones", done_cyc - d0, 1);
    check("t5_triggers", trig_cyc - t0, 1);
    check("t5_exp_rises", exp_rise - r0, 1);
    check("t5_no_err", {31'd0, err_timeout}, 0);

    // start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    check("c_ss_busy", {31'd0, run_busy}, 0);
    check("c_ss_exp", {31'd0, EXP}, 0);

    // Reset while in WAIT_DONE of the second frame.
    cfg(2, 0, 0, 0, 6);
    pulse_start();
    wait_for("c_rst_frame", 5, 1'b1, 100, cyc);
    wait_for("c_rst_rb", 1, 1'b1, 50, cyc);
    @(negedge CLK);
    check("c_rst_pre_busy", {31'd0, run_busy}, 1);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    check("c_rst_trigger", {31'd0, trigger}, 0);
    check("c_rst_exp", {31'd0, EXP}, 0);
    check("c_rst_busy", {31'd0, run_busy}, 0);
    check("c_rst_done", {31'd0, done}, 0);
    check("c_rst_err", {31'd0, err_timeout}, 0);
    check("c_rst_fcnt", frame_cnt, 0);
    d0 = done_cyc;
    repeat (20) @(negedge CLK);
    check("c_rst_stays_idle", {31'd0, run_busy}, 0);
    check("c_rst_no_done", done_cyc - d0, 0);

    check("trig_never_double", trig_double, 0);
    check("trig_follows_exp", trig_after_exp, trig_cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/readout_trigger_ctrl.md
# readout_trigger_ctrl

Frame-level initiator for the row readout sequencer. Runs exposure, issues the readout `trigger` pulse, and tracks the sequencer's `re_busy` through acknowledge and completion. Repeats for a programmed number of frames, with a gap between frames. Sits between host-side register control and the readout sequencer, on the same `CLK` domain.

## Interface
Parameters:
- `CNT_W`, 32: width of all timing and frame-count fields.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: system clock, same clock as the readout sequencer.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level sampled per cycle; starts a run when in IDLE.
- `stop` in 1: level sampled per cycle; requests graceful end of the run.
- `T_exp` in CNT_W: exposure length in cycles; 0 is treated as 1.
- `T_gap` in CNT_W: idle cycles between frames; 0 means no gap.
- `T_timeout` in CNT_W: maximum cycles to wait for `re_busy` to rise; 0 disables the timeout.
- `NUM_FRAME` in CNT_W: frames per run; 0 means continuous until `stop`.
- `re_busy` in 1: busy flag from the readout sequencer.
- `trigger` out 1: one-cycle readout request to the sequencer.
- `EXP` out 1: high while exposing.
- `run_busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the run ends normally.
- `err_timeout` out 1: sticky flag; cleared by `rst` or by an accepted `start`.
- `frame_cnt` out CNT_W: frames completed in the current run.

## Operation
- States: IDLE, EXPOSE, TRIG, WAIT_ACK, WAIT_DONE, GAP.
- IDLE, with `start`=1 and `stop`=0:
  - latch `T_exp`, `T_gap`, `T_timeout` and `NUM_FRAME`;
  - clear `frame_cnt` and `err_timeout`;
  - go to EXPOSE.
- Inputs changing mid-run have no effect.
- `start` is ignored outside IDLE. If `start` and `stop` are both high in IDLE, stop wins and the block stays in IDLE.
- EXPOSE: `EXP`=1 for max(T_exp,1) cycles, then go to TRIG.
- TRIG: `trigger`=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - `re_busy`=1 → go to WAIT_DONE.
  - If `T_timeout`≠0 and T_timeout cycles pass without `re_busy`: set `err_timeout`, go to IDLE, no `done` pulse.
- WAIT_DONE: on `re_busy`=0, increment `frame_cnt`. Then:
  - if the new count equals `NUM_FRAME` (and `NUM_FRAME`≠0), or stop is pending: go to IDLE and pulse `done`;
  - otherwise go to GAP, or directly to EXPOSE if `T_gap`=0.
- GAP: wait T_gap cycles, then go to EXPOSE.
- `stop` handling:
  - In EXPOSE or GAP, stop aborts at the next edge: return to IDLE, drop `EXP`, pulse `done`; `frame_cnt` is unchanged.
  - In TRIG, WAIT_ACK or WAIT_DONE, stop is latched as stop-pending. The current readout completes, then the run ends.
  - Stop-pending is cleared in IDLE.
- `frame_cnt` wraps at 2^CNT_W with no flag.
- Reset during any state: return to IDLE at the next edge. `trigger` and `EXP` drop immediately; no `done` pulse.

## Timing
- All outputs are registered.
- Reset values: `trigger`=0, `EXP`=0, `run_busy`=0, `done`=0, `err_timeout`=0, `frame_cnt`=0; state is IDLE.
- Start latency: `start` sampled at edge n → `EXP` and `run_busy` high from edge n.
- `trigger` is high in the cycle immediately after the last `EXP` cycle. It is never high for two consecutive cycles, because the sequencer re-arms on a held level.
- With the sequencer, `re_busy` rises 2 cycles after `trigger` rises. A `T_timeout` below 2 therefore always times out; this is legal and is tested.
- Timeout counting starts in the first WAIT_ACK cycle.
- Frame completion: `re_busy` sampled 0 at edge m → `frame_cnt` updated at edge m. `done` (if any) is high for the cycle after edge m, and `run_busy` falls at that same edge.
- Frame period in steady state: T_exp + 1 (TRIG) + ack latency + readout time + T_gap cycles.

## Structure
- Shared package `readout_pkg` holds:
  - state encoding localparams: RTC_IDLE, RTC_EXPOSE, RTC_TRIG, RTC_WAIT_ACK, RTC_WAIT_DONE, RTC_GAP;
  - the `CNT_W` default.
- One sub-module, `cycle_timer`: loadable down-counter with `load`, `value` and `expired` outputs. It is reused for the exposure, gap and timeout timers; one instance, reloaded per state.
- A behavioural model of the readout sequencer handshake lives in the bench. It is not part of the RTL.

## Test plan
- Single frame. `T_exp`=5, `NUM_FRAME`=1, sequencer model with a 20-cycle readout, `start` pulse. Expect:
  - `EXP` high exactly 5 cycles;
  - one `trigger` pulse;
  - `frame_cnt`=1;
  - one `done` pulse;
  - `run_busy` low afterwards.
- Multi-frame. `NUM_FRAME`=3, `T_gap`=4. Expect:
  - 3 triggers;
  - exactly 4 idle cycles between each `re_busy` fall and the next `EXP` rise;
  - `done` after the third frame.
- Timeout. `T_timeout`=10 with `re_busy` tied to 0. Expect:
  - `err_timeout`=1 exactly 10 cycles after entering WAIT_ACK;
  - return to IDLE with no `done`;
  - the next `start` clears `err_timeout`.
- Stop mid-exposure. `T_exp`=100, `stop` at cycle 30. Expect:
  - `EXP` drops next cycle;
  - `done` pulses;
  - no `trigger`;
  - `frame_cnt`=0.
- Stop during readout with `NUM_FRAME`=0, `stop` asserted while `re_busy`=1. Expect:
  - the readout completes;
  - `frame_cnt` increments once;
  - `done` pulses;
  - no further `EXP`.
- Corner cases:
  - `start` while running is ignored;
  - `start` and `stop` together in IDLE: the block stays in IDLE;
  - `rst` in WAIT_DONE returns all outputs to their reset values the next cycle.
